// File: rtl/rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// rx_link_ctrl
// Link bring-up and supervision controller for the two-lane PHY receive path.
// Sequences the link WAIT_ACTIVE -> DESKEW -> LINK_UP, with RECOVERY used for
// every teardown (skew error, lane mismatch, active loss, forced retrain).
// rx_enable gates the striping mux valid and is high only while in LINK_UP.
//
// Optional feature (macro RX_LINK_IDLE_TIMEOUT_EN): when defined, LINK_UP is
// dropped to RECOVERY after IDLE_TIMEOUT consecutive cycles with no valid on
// either lane. When undefined the link may stay idle indefinitely.
//
// Ports:
//   clk_4f                     block clock
//   reset                      synchronous active-low reset
//   active_serial_paralelo_0/1 per-lane aligned/active flags
//   valid_demux_8_32_0/1       per-lane 32-bit word valid
//   force_retrain              single-cycle request to drop and retrain
//   clear_fault                single-cycle clear of lane_fault
//   rx_enable                  striping mux valid gate (registered)
//   link_up                    link established (registered)
//   link_state                 0=WAIT_ACTIVE 1=DESKEW 2=LINK_UP 3=RECOVERY
//   lane_fault                 sticky per-lane loss-of-active flags
//   skew_err_cnt               saturating deskew/mismatch error count
//   retrain_cnt                saturating count of completed recoveries
// -----------------------------------------------------------------------------
module rx_link_ctrl #(
    parameter int unsigned ACTIVE_HOLD     = 4,
    parameter int unsigned DESKEW_WINDOW   = 2,
    parameter int unsigned MISMATCH_LIMIT  = 3,
    parameter int unsigned RECOVERY_CYCLES = 8,
    parameter int unsigned IDLE_TIMEOUT    = 64
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       active_serial_paralelo_0,
    input  logic       active_serial_paralelo_1,
    input  logic       valid_demux_8_32_0,
    input  logic       valid_demux_8_32_1,
    input  logic       force_retrain,
    input  logic       clear_fault,
    output logic       rx_enable,
    output logic       link_up,
    output logic [1:0] link_state,
    output logic [1:0] lane_fault,
    output logic [7:0] skew_err_cnt,
    output logic [7:0] retrain_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT_ACTIVE = 2'd0,
        ST_DESKEW      = 2'd1,
        ST_LINK_UP     = 2'd2,
        ST_RECOVERY    = 2'd3
    } state_t;

    // Terminal values: each counter fires on the cycle it would reach its limit.
    localparam logic [7:0]  HOLD_LAST = 8'(ACTIVE_HOLD - 32'd1);
    localparam logic [4:0]  SKEW_MAX  = 5'(DESKEW_WINDOW);
    localparam logic [3:0]  MIS_LAST  = 4'(MISMATCH_LIMIT - 32'd1);
    localparam logic [7:0]  REC_LAST  = 8'(RECOVERY_CYCLES - 32'd1);

    // Elaboration-time range checks on the configuration.
    if ((ACTIVE_HOLD < 32'd1) || (ACTIVE_HOLD > 32'd255)) begin : g_chk_hold
        $error("rx_link_ctrl: ACTIVE_HOLD out of range 1..255");
    end
    if (DESKEW_WINDOW > 32'd15) begin : g_chk_skew
        $error("rx_link_ctrl: DESKEW_WINDOW out of range 0..15");
    end
    if ((MISMATCH_LIMIT < 32'd1) || (MISMATCH_LIMIT > 32'd15)) begin : g_chk_mis
        $error("rx_link_ctrl: MISMATCH_LIMIT out of range 1..15");
    end
    if ((RECOVERY_CYCLES < 32'd1) || (RECOVERY_CYCLES > 32'd255)) begin : g_chk_rec
        $error("rx_link_ctrl: RECOVERY_CYCLES out of range 1..255");
    end
    if ((IDLE_TIMEOUT < 32'd1) || (IDLE_TIMEOUT > 32'd65535)) begin : g_chk_idle
        $error("rx_link_ctrl: IDLE_TIMEOUT out of range 1..65535");
    end

    // Saturating 8-bit increment for the statistics counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    state_t      state_r, state_next_s;
    logic        rx_enable_r, link_up_r;
    logic [1:0]  lane_fault_r;
    logic [7:0]  skew_err_cnt_r, retrain_cnt_r;

    logic [7:0]  hold_cnt_r, hold_cnt_next_s;
    logic [4:0]  skew_cnt_r, skew_cnt_next_s;   // cycles elapsed since first valid
    logic        seen_r, seen_next_s;           // first valid observed in DESKEW
    logic        first_lane_r, first_lane_next_s;
    logic [3:0]  mis_cnt_r, mis_cnt_next_s;
    logic [7:0]  rec_cnt_r, rec_cnt_next_s;

    logic        err_inc_s, retrain_inc_s;
    logic [1:0]  fault_set_s;
    logic        both_active_s, mis_s, other_valid_s, idle_expire_s;

    assign both_active_s = active_serial_paralelo_0 & active_serial_paralelo_1;
    assign mis_s         = valid_demux_8_32_0 ^ valid_demux_8_32_1;
    // The lane that did not produce the first valid in DESKEW.
    assign other_valid_s = first_lane_r ? valid_demux_8_32_0 : valid_demux_8_32_1;

`ifdef RX_LINK_IDLE_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 32'd1);
    logic [15:0] idle_cnt_r, idle_cnt_next_s;
    logic        idle_s;
    assign idle_s        = ~(valid_demux_8_32_0 | valid_demux_8_32_1);
    assign idle_expire_s = idle_s & (idle_cnt_r == IDLE_LAST);
`else
    assign idle_expire_s = 1'b0;
`endif

    // Next-state, event and internal-counter decode.
    always_comb begin
        state_next_s      = state_r;
        err_inc_s         = 1'b0;
        retrain_inc_s     = 1'b0;
        fault_set_s       = 2'b00;
        hold_cnt_next_s   = hold_cnt_r;
        skew_cnt_next_s   = skew_cnt_r;
        seen_next_s       = seen_r;
        first_lane_next_s = first_lane_r;
        mis_cnt_next_s    = mis_cnt_r;
        rec_cnt_next_s    = rec_cnt_r;
`ifdef RX_LINK_IDLE_TIMEOUT_EN
        idle_cnt_next_s   = idle_cnt_r;
`endif
        case (state_r)
            ST_WAIT_ACTIVE: begin
                if (force_retrain) begin
                    state_next_s = ST_RECOVERY;
                end else if (!both_active_s) begin
                    hold_cnt_next_s = 8'd0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_next_s = ST_DESKEW;
                end else begin
                    hold_cnt_next_s = hold_cnt_r + 8'd1;
                end
            end
            ST_DESKEW: begin
                if (!both_active_s) begin
                    state_next_s = ST_WAIT_ACTIVE;
                end else if (seen_r && (skew_cnt_r > SKEW_MAX)) begin
                    err_inc_s    = 1'b1;
                    state_next_s = ST_RECOVERY;
                end else if (force_retrain) begin
                    state_next_s = ST_RECOVERY;
                end else if (seen_r) begin
                    if (other_valid_s) begin
                        state_next_s = ST_LINK_UP;
                    end else begin
                        skew_cnt_next_s = skew_cnt_r + 5'd1;
                    end
                end else if (valid_demux_8_32_0 && valid_demux_8_32_1) begin
                    state_next_s = ST_LINK_UP;
                end else if (valid_demux_8_32_0 || valid_demux_8_32_1) begin
                    // Next cycle is one cycle after the first valid.
                    seen_next_s       = 1'b1;
                    first_lane_next_s = valid_demux_8_32_1;
                    skew_cnt_next_s   = 5'd1;
                end else begin
                    seen_next_s = 1'b0;
                end
            end
            ST_LINK_UP: begin
                if (!both_active_s) begin
                    fault_set_s  = {~active_serial_paralelo_1, ~active_serial_paralelo_0};
                    state_next_s = ST_RECOVERY;
                end else if (mis_s && (mis_cnt_r == MIS_LAST)) begin
                    err_inc_s    = 1'b1;
                    state_next_s = ST_RECOVERY;
                end else if (force_retrain) begin
                    state_next_s = ST_RECOVERY;
                end else if (idle_expire_s) begin
                    state_next_s = ST_RECOVERY;
                end else begin
                    mis_cnt_next_s = mis_s ? (mis_cnt_r + 4'd1) : 4'd0;
`ifdef RX_LINK_IDLE_TIMEOUT_EN
                    idle_cnt_next_s = idle_s ? (idle_cnt_r + 16'd1) : 16'd0;
`endif
                end
            end
            ST_RECOVERY: begin
                if (rec_cnt_r == REC_LAST) begin
                    retrain_inc_s = 1'b1;
                    state_next_s  = ST_WAIT_ACTIVE;
                end else begin
                    rec_cnt_next_s = rec_cnt_r + 8'd1;
                end
            end
            default: begin
                state_next_s = ST_WAIT_ACTIVE;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_r        <= ST_WAIT_ACTIVE;
            rx_enable_r    <= 1'b0;
            link_up_r      <= 1'b0;
            lane_fault_r   <= 2'b00;
            skew_err_cnt_r <= 8'd0;
            retrain_cnt_r  <= 8'd0;
        end else begin
            state_r        <= state_next_s;
            rx_enable_r    <= (state_next_s == ST_LINK_UP);
            link_up_r      <= (state_next_s == ST_LINK_UP);
            // Set wins over clear on the same cycle.
            lane_fault_r   <= (lane_fault_r & {2{~clear_fault}}) | fault_set_s;
            skew_err_cnt_r <= err_inc_s ? sat_inc8(skew_err_cnt_r) : skew_err_cnt_r;
            retrain_cnt_r  <= retrain_inc_s ? sat_inc8(retrain_cnt_r) : retrain_cnt_r;
        end
    end

    // Internal counters; all of them restart on every state entry.
    always_ff @(posedge clk_4f) begin
        if (!reset || (state_next_s != state_r)) begin
            hold_cnt_r   <= 8'd0;
            skew_cnt_r   <= 5'd0;
            seen_r       <= 1'b0;
            first_lane_r <= 1'b0;
            mis_cnt_r    <= 4'd0;
            rec_cnt_r    <= 8'd0;
`ifdef RX_LINK_IDLE_TIMEOUT_EN
            idle_cnt_r   <= 16'd0;
`endif
        end else begin
            hold_cnt_r   <= hold_cnt_next_s;
            skew_cnt_r   <= skew_cnt_next_s;
            seen_r       <= seen_next_s;
            first_lane_r <= first_lane_next_s;
            mis_cnt_r    <= mis_cnt_next_s;
            rec_cnt_r    <= rec_cnt_next_s;
`ifdef RX_LINK_IDLE_TIMEOUT_EN
            idle_cnt_r   <= idle_cnt_next_s;
`endif
        end
    end

    assign rx_enable    = rx_enable_r;
    assign link_up      = link_up_r;
    assign link_state   = state_r;
    assign lane_fault   = lane_fault_r;
    assign skew_err_cnt = skew_err_cnt_r;
    assign retrain_cnt  = retrain_cnt_r;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_link_ctrl
// Scoreboard bench for rx_link_ctrl. Each stimulus cycle runs a timestamp-based
// reference model and queues the expected post-edge outputs; a monitor pops and
// compares every cycle. Directed scenarios add absolute checks on top.
// -----------------------------------------------------------------------------
module tb_rx_link_ctrl;

    localparam int ACTIVE_HOLD     = 4;
    localparam int DESKEW_WINDOW   = 2;
    localparam int MISMATCH_LIMIT  = 3;
    localparam int RECOVERY_CYCLES = 8;
    localparam int IDLE_TIMEOUT    = 64;

    logic       clk_4f, reset;
    logic       act0, act1, val0, val1, force_retrain, clear_fault;
    logic       rx_enable, link_up;
    logic [1:0] link_state, lane_fault;
    logic [7:0] skew_err_cnt, retrain_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       up;
        logic [1:0] flt;
        logic [7:0] err;
        logic [7:0] rtr;
    } obs_t;

    obs_t exp_q[$];

    rx_link_ctrl dut (
        .clk_4f                   (clk_4f),
        .reset                    (reset),
        .active_serial_paralelo_0 (act0),
        .active_serial_paralelo_1 (act1),
        .valid_demux_8_32_0       (val0),
        .valid_demux_8_32_1       (val1),
        .force_retrain            (force_retrain),
        .clear_fault              (clear_fault),
        .rx_enable                (rx_enable),
        .link_up                  (link_up),
        .link_state               (link_state),
        .lane_fault               (lane_fault),
        .skew_err_cnt             (skew_err_cnt),
        .retrain_cnt              (retrain_cnt)
    );

    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    // ---------------- reference model (timestamps, not counters) -------------
    int         m_state;       // 0 wait, 1 deskew, 2 link up, 3 recovery
    int         m_cyc;
    int         m_entry;       // first cycle spent in the current state
    int         m_break;       // last cycle where both lanes were not active
    int         m_first;       // cycle of first valid in deskew, -1 if none
    int         m_first_lane;
    int         m_agree_last;  // last link-up cycle where valids agreed
    int         m_busy_last;   // last link-up cycle with any valid
    logic [1:0] m_fault;
    int         m_err, m_retrain;

    task automatic model_enter();
        m_entry      = m_cyc + 1;
        m_break      = m_cyc;
        m_first      = -1;
        m_agree_last = m_cyc;
        m_busy_last  = m_cyc;
    endtask

    task automatic model_step(input logic a0, a1, v0, v1, fr, cf, rst);
        int nxt;
        logic [1:0] fset;
        bit both;
        nxt  = m_state;
        fset = 2'b00;
        both = a0 && a1;
        if (!rst) begin
            m_state = 0; m_fault = 2'b00; m_err = 0; m_retrain = 0;
            model_enter();
            m_cyc++;
            return;
        end
        case (m_state)
            0: begin
                if (fr) nxt = 3;
                else if (!both) m_break = m_cyc;
                else if (m_cyc - m_break == ACTIVE_HOLD) nxt = 1;
            end
            1: begin
                if (!both) nxt = 0;
                else if (m_first >= 0 && (m_cyc - m_first) > DESKEW_WINDOW) begin
                    nxt = 3;
                    if (m_err < 255) m_err++;
                end else if (fr) nxt = 3;
                else if (m_first < 0) begin
                    if (v0 && v1) nxt = 2;
                    else if (v0 || v1) begin m_first = m_cyc; m_first_lane = v1 ? 1 : 0; end
                end else if ((m_first_lane == 1) ? v0 : v1) nxt = 2;
            end
            2: begin
                if (!both) begin fset = {!a1, !a0}; nxt = 3; end
                else if ((v0 != v1) && (m_cyc - m_agree_last == MISMATCH_LIMIT)) begin
                    nxt = 3;
                    if (m_err < 255) m_err++;
                end else if (fr) nxt = 3;
`ifdef RX_LINK_IDLE_TIMEOUT_EN
                else if (!v0 && !v1 && (m_cyc - m_busy_last == IDLE_TIMEOUT)) nxt = 3;
`endif
                else begin
                    if (v0 == v1) m_agree_last = m_cyc;
                    if (v0 || v1) m_busy_last = m_cyc;
                end
            end
            default: begin
                if (m_cyc - m_entry + 1 == RECOVERY_CYCLES) begin
                    nxt = 0;
                    if (m_retrain < 255) m_retrain++;
                end
            end
        endcase
        m_fault = (cf ? 2'b00 : m_fault) | fset;
        if (nxt != m_state) begin
            m_state = nxt;
            model_enter();
        end
        m_cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic a0, a1, v0, v1, fr, cf, rst);
        obs_t e;
        @(negedge clk_4f);
        act0 = a0; act1 = a1; val0 = v0; val1 = v1;
        force_retrain = fr; clear_fault = cf; reset = rst;
        model_step(a0, a1, v0, v1, fr, cf, rst);
        e.st  = 2'(m_state);
        e.en  = (m_state == 2);
        e.up  = (m_state == 2);
        e.flt = m_fault;
        e.err = 8'(m_err);
        e.rtr = 8'(m_retrain);
        exp_q.push_back(e);
    endtask

    // Active-only cycle with the given valids.
    task automatic run(input logic v0, v1);
        cyc(1'b1, 1'b1, v0, v1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_to_deskew();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (ACTIVE_HOLD) run(1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk_4f);
            #1;
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = {link_state, rx_enable, link_up, lane_fault, skew_err_cnt, retrain_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL obs t=%0t: got st=%0d en=%0b up=%0b flt=%b err=%0d rtr=%0d expected st=%0d en=%0b up=%0b flt=%b err=%0d rtr=%0d",
                             $time, a.st, a.en, a.up, a.flt, a.err, a.rtr,
                             e.st, e.en, e.up, e.flt, e.err, e.rtr);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        act0 = 1'b0; act1 = 1'b0; val0 = 1'b0; val1 = 1'b0;
        force_retrain = 1'b0; clear_fault = 1'b0; reset = 1'b0;
        m_cyc = 0; m_state = 0; m_fault = 2'b00; m_err = 0; m_retrain = 0;
        m_first_lane = 0;
        model_enter();

        // Bring-up
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("reset_state", int'(link_state), 0);
        chk("reset_outs", int'({rx_enable, link_up, lane_fault, skew_err_cnt, retrain_cnt}), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (ACTIVE_HOLD - 1) run(1'b0, 1'b0);
        settle();
        chk("hold_not_done", int'(link_state), 0);
        run(1'b0, 1'b0);
        settle();
        chk("deskew_entry", int'(link_state), 1);
        repeat (2) run(1'b0, 1'b0);
        run(1'b1, 1'b1);
        settle();
        chk("bringup_link_up", int'({link_up, rx_enable}), 3);
        chk("bringup_skew_err", int'(skew_err_cnt), 0);

        // Skew at the window limit
        reset_to_deskew();
        run(1'b1, 1'b0);
        run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        settle();
        chk("skew2_link_up", int'(link_state), 2);

        // Skew one past the window
        reset_to_deskew();
        run(1'b1, 1'b0);
        run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        settle();
        chk("skew3_recovery", int'(link_state), 3);
        chk("skew3_err", int'(skew_err_cnt), 1);
        repeat (RECOVERY_CYCLES - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("rec_still", int'(link_state), 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("rec_done_state", int'(link_state), 0);
        chk("rec_done_retrain", int'(retrain_cnt), 1);

        // Active loss beats a mismatch at its limit
        reset_to_deskew();
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("loss_fault", int'(lane_fault), 2);
        chk("loss_err", int'(skew_err_cnt), 0);
        chk("loss_state", int'(link_state), 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("fault_clear", int'(lane_fault), 0);

        // Mismatch tolerance
        reset_to_deskew();
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);
        run(1'b1, 1'b0);
        run(1'b1, 1'b1);
        settle();
        chk("mis2_stays", int'(link_state), 2);
        repeat (MISMATCH_LIMIT) run(1'b1, 1'b0);
        settle();
        chk("mis3_state", int'(link_state), 3);
        chk("mis3_err", int'(skew_err_cnt), 1);

        // Retrain saturation, then reset in RECOVERY
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            repeat (RECOVERY_CYCLES) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        settle();
        chk("retrain_sat", int'(retrain_cnt), 255);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("pre_reset_rec", int'(link_state), 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("midrun_reset", int'({link_state, rx_enable, link_up, lane_fault, skew_err_cnt, retrain_cnt}), 0);

        // Idle supervision
        reset_to_deskew();
        run(1'b1, 1'b1);
        repeat (IDLE_TIMEOUT - 1) run(1'b0, 1'b0);
        settle();
        chk("idle63_stays", int'(link_state), 2);
`ifdef RX_LINK_IDLE_TIMEOUT_EN
        run(1'b0, 1'b0);
        settle();
        chk("idle64_recovery", int'(link_state), 3);
`else
        repeat (1000 - IDLE_TIMEOUT + 1) run(1'b0, 1'b0);
        settle();
        chk("idle1000_stays", int'(link_state), 2);
`endif

        // Randomised phase checked by the scoreboard
        for (int i = 0; i < 4000; i++) begin
            logic r_a0, r_a1, r_v0, r_v1, r_fr, r_cf, r_rst, r_same;
            r_a0   = ($urandom_range(0, 24) != 0);
            r_a1   = ($urandom_range(0, 24) != 0);
            r_same = ($urandom_range(0, 3) != 0);
            r_v0   = 1'($urandom_range(0, 1));
            r_v1   = r_same ? r_v0 : 1'($urandom_range(0, 1));
            r_fr   = ($urandom_range(0, 79) == 0);
            r_cf   = ($urandom_range(0, 15) == 0);
            r_rst  = ($urandom_range(0, 599) != 0);
            cyc(r_a0, r_a1, r_v0, r_v1, r_fr, r_cf, r_rst);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) settle();
        chk("scoreboard_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
